// File: rtl/key_event_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// key_event_arbiter : per-key press/long/release strobes, round-robin arbitrated
//                     into an event FIFO with a sticky lost-event flag.  Rev 1.0
// -----------------------------------------------------------------------------
module key_event_arbiter #(
    parameter int N_KEYS      = 4,
    parameter int LONG_CYCLES = 50000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_KEYS-1:0]             key,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(N_KEYS)-1:0]     evt_key,
    output logic [1:0]                    evt_type,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf,
    input  logic                          clr_ovf
);

    localparam int c_KW = $clog2(N_KEYS);
    localparam int c_SW = c_KW + 1;
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(LONG_CYCLES);

    localparam logic [c_CW-1:0] c_HOLD_MAX = c_CW'(LONG_CYCLES - 1);
    localparam logic [c_CW-1:0] c_HOLD_PRE = c_CW'(LONG_CYCLES - 2);
    localparam logic [c_PW:0]   c_FULL     = (c_PW + 1)'(FIFO_DEPTH);
    localparam logic [1:0]      c_EVT_PRESS = 2'b00;
    localparam logic [1:0]      c_EVT_LONG  = 2'b01;
    localparam logic [1:0]      c_EVT_REL   = 2'b10;

    logic [N_KEYS-1:0]   r_key_q;
    logic [N_KEYS-1:0]   r_pend_p, r_pend_l, r_pend_r;
    logic [c_KW-1:0]     r_last;
    logic                r_ovf;
    logic [c_KW+1:0]     r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]     r_wr, r_rd;
    logic [c_PW:0]       r_count;

    logic [N_KEYS-1:0]   w_press, w_release, w_long;
    logic [N_KEYS-1:0]   w_any, w_rot, w_gnt_oh;
    logic [2*N_KEYS-1:0] w_any2;
    logic [N_KEYS-1:0]   w_clr_p, w_clr_l, w_clr_r;
    logic [c_KW-1:0]     w_start, w_gnt_key;
    logic [c_SW-1:0]     w_gnt_sum;
    logic [1:0]          w_gnt_type;
    logic                w_gnt_ok, w_gnt, w_pop, w_lost;

    assign w_press   = key & ~r_key_q;
    assign w_release = ~key & r_key_q;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [c_CW-1:0] r_hold;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold <= '0;
                end else if (!r_key_q[gi]) begin
                    r_hold <= '0;
                end else if (r_hold != c_HOLD_MAX) begin
                    r_hold <= r_hold + 1'b1;
                end
            end

            // Strobe on the increment that lands on LONG_CYCLES-1, never again while saturated
            assign w_long[gi] = r_key_q[gi] && (r_hold == c_HOLD_PRE);
        end
    endgenerate

    // Round-robin search: rotate the request vector so bit 0 is the key after the last grant
    assign w_any   = r_pend_p | r_pend_l | r_pend_r;
    assign w_any2  = {w_any, w_any};
    assign w_start = (r_last == c_KW'(N_KEYS - 1)) ? '0 : r_last + 1'b1;
    assign w_rot   = w_any2[w_start +: N_KEYS];

    always_comb begin
        w_gnt_ok  = 1'b0;
        w_gnt_sum = '0;
        for (int j = 0; j < N_KEYS; j++) begin
            if (!w_gnt_ok && w_rot[j]) begin
                w_gnt_ok  = 1'b1;
                w_gnt_sum = {1'b0, w_start} + c_SW'(j);
            end
        end
        if (w_gnt_sum >= c_SW'(N_KEYS)) begin
            w_gnt_key = c_KW'(w_gnt_sum - c_SW'(N_KEYS));
        end else begin
            w_gnt_key = c_KW'(w_gnt_sum);
        end
        if (r_pend_p[w_gnt_key]) begin
            w_gnt_type = c_EVT_PRESS;
        end else if (r_pend_l[w_gnt_key]) begin
            w_gnt_type = c_EVT_LONG;
        end else begin
            w_gnt_type = c_EVT_REL;
        end
    end

    assign w_gnt    = w_gnt_ok && (r_count < c_FULL);
    assign w_pop    = evt_valid && evt_ready;
    assign w_gnt_oh = w_gnt ? (N_KEYS'(1) << w_gnt_key) : '0;
    assign w_clr_p  = w_gnt_oh & {N_KEYS{w_gnt_type == c_EVT_PRESS}};
    assign w_clr_l  = w_gnt_oh & {N_KEYS{w_gnt_type == c_EVT_LONG}};
    assign w_clr_r  = w_gnt_oh & {N_KEYS{w_gnt_type == c_EVT_REL}};

    // A strobe on a flag that is still pending and not leaving this cycle is dropped
    assign w_lost = |((w_press   & r_pend_p & ~w_clr_p) |
                      (w_long    & r_pend_l & ~w_clr_l) |
                      (w_release & r_pend_r & ~w_clr_r));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_q  <= '0;
            r_pend_p <= '0;
            r_pend_l <= '0;
            r_pend_r <= '0;
            r_last   <= c_KW'(N_KEYS - 1);
            r_ovf    <= 1'b0;
        end else begin
            r_key_q  <= key;
            r_pend_p <= w_press   | (r_pend_p & ~w_clr_p);
            r_pend_l <= w_long    | (r_pend_l & ~w_clr_l);
            r_pend_r <= w_release | (r_pend_r & ~w_clr_r);
            if (w_gnt) begin
                r_last <= w_gnt_key;
            end
            if (w_lost) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_gnt) begin
                r_mem[r_wr] <= {w_gnt_key, w_gnt_type};
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_gnt, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt_valid             = (r_count != '0);
    assign {evt_key, evt_type}   = r_mem[r_rd];
    assign fifo_count            = r_count;
    assign ovf                   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_key_event_arbiter : directed tables, corner sequences and randomized
//                        stimulus against a queue-based event model.  Rev 1.0
// -----------------------------------------------------------------------------
module tb_key_event_arbiter;

    localparam int N_KEYS      = 4;
    localparam int LONG_CYCLES = 10;
    localparam int FIFO_DEPTH  = 4;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] key       = '0;
    logic       evt_ready = 1'b0;
    logic       clr_ovf   = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic [2:0] fifo_count;
    logic       ovf;

    key_event_arbiter #(
        .N_KEYS      (N_KEYS),
        .LONG_CYCLES (LONG_CYCLES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_key    (evt_key),
        .evt_type   (evt_type),
        .fifo_count (fifo_count),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: events are key*4+type in a plain queue
    bit m_prev [N_KEYS];
    int m_hold [N_KEYS];
    bit m_pend [N_KEYS][3];
    int m_last;
    int m_q[$];
    bit m_ovf;

    task automatic model_reset();
        for (int i = 0; i < N_KEYS; i++) begin
            m_prev[i] = 1'b0;
            m_hold[i] = 0;
            for (int t = 0; t < 3; t++) m_pend[i][t] = 1'b0;
        end
        m_last = N_KEYS - 1;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] k, input bit rdy, input bit clr);
        bit strobe [N_KEYS][3];
        bit lost;
        bit granted;
        int gk;
        int gt;
        int idx;
        lost = 1'b0;
        gk   = -1;
        gt   = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            strobe[i][0] = k[i] && !m_prev[i];
            strobe[i][1] = m_prev[i] && (m_hold[i] + 1 == LONG_CYCLES - 1);
            strobe[i][2] = !k[i] && m_prev[i];
        end
        if (m_q.size() < FIFO_DEPTH) begin
            for (int off = 1; off <= N_KEYS; off++) begin
                idx = (m_last + off) % N_KEYS;
                for (int t = 0; t < 3; t++) begin
                    if (gk < 0 && m_pend[idx][t]) begin
                        gk = idx;
                        gt = t;
                    end
                end
            end
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        for (int i = 0; i < N_KEYS; i++) begin
            for (int t = 0; t < 3; t++) begin
                granted = (i == gk) && (t == gt);
                if (strobe[i][t] && m_pend[i][t] && !granted) lost = 1'b1;
                m_pend[i][t] = strobe[i][t] || (m_pend[i][t] && !granted);
            end
        end
        if (gk >= 0) begin
            m_q.push_back(gk * 4 + gt);
            m_last = gk;
        end
        for (int i = 0; i < N_KEYS; i++) begin
            if (!m_prev[i])                      m_hold[i] = 0;
            else if (m_hold[i] < LONG_CYCLES - 1) m_hold[i] = m_hold[i] + 1;
            m_prev[i] = k[i];
        end
        if (lost)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic tick();
        model_step(key, evt_ready, clr_ovf);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.valid", evt_valid, 0);
        check("rst.key", evt_key, 0);
        check("rst.type", evt_type, 0);
        check("rst.count", fifo_count, 0);
        check("rst.ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"}, evt_valid, m_q.size() != 0);
        check({tag, ".count"}, fifo_count, m_q.size());
        check({tag, ".ovf"}, ovf, m_ovf);
        if (m_q.size() != 0) begin
            check({tag, ".key"}, evt_key, m_q[0] / 4);
            check({tag, ".type"}, evt_type, m_q[0] % 4);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] k;
        bit         rdy;
        bit         v;
        int         ek;
        int         et;
        int         cnt;
    } vec_t;

    vec_t tbl [18];
    int   ev[$];
    int   exp_bp [6];
    int   n_long;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // single press / release on key 2, then simultaneous press and release of all keys
        tbl[0]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 2, 0, 1};
        tbl[2]  = '{1'b0, 4'b0100, 1'b1, 1'b0, 0, 0, 0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 2, 2, 1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[6]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 0, 0, 0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 0, 0, 1};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 1, 0, 1};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2, 0, 1};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 1'b1, 3, 0, 1};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 1'b0, 0, 0, 0};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 0, 2, 1};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1, 2, 1};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2, 2, 1};
        tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b1, 3, 2, 1};
        tbl[17] = '{1'b0, 4'b0000, 1'b1, 1'b0, 0, 0, 0};
        exp_bp = '{0, 4, 8, 2, 6, 10};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) do_reset();
            key       = tbl[i].k;
            evt_ready = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d.valid", i), evt_valid, tbl[i].v);
            check($sformatf("tbl%0d.count", i), fifo_count, tbl[i].cnt);
            if (tbl[i].v) begin
                check($sformatf("tbl%0d.key", i), evt_key, tbl[i].ek);
                check($sformatf("tbl%0d.type", i), evt_type, tbl[i].et);
            end
        end

        // long press on key 1: press, long, release in that order, exactly one long
        do_reset();
        evt_ready = 1'b1;
        key       = 4'b0010;
        ev.delete();
        for (int c = 0; c < 26; c++) begin
            if (c == 20) key = 4'b0000;
            tick();
            if (evt_valid) ev.push_back(evt_key * 4 + evt_type);
        end
        n_long = 0;
        foreach (ev[i]) if (ev[i] % 4 == 1) n_long++;
        check("long.n_events", ev.size(), 3);
        check("long.n_long", n_long, 1);
        check("long.ev0", (ev.size() > 0) ? ev[0] : -1, 4);
        check("long.ev1", (ev.size() > 1) ? ev[1] : -1, 5);
        check("long.ev2", (ev.size() > 2) ? ev[2] : -1, 6);

        // backpressure: six events, four queued, two held pending
        do_reset();
        evt_ready = 1'b0;
        key       = 4'b0111;
        tick();
        key = 4'b0000;
        for (int c = 0; c < 8; c++) tick();
        check("bp.count", fifo_count, 4);
        check("bp.ovf", ovf, 0);
        check("bp.head", evt_key * 4 + evt_type, 0);
        evt_ready = 1'b1;
        ev.delete();
        for (int c = 0; c < 12; c++) begin
            if (evt_valid) ev.push_back(evt_key * 4 + evt_type);
            tick();
        end
        check("bp.n_events", ev.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp.ev%0d", i), (ev.size() > i) ? ev[i] : -1, exp_bp[i]);
        end
        check("bp.ovf_end", ovf, 0);

        // overflow: FIFO full, key 0 toggled until a press strobe hits a pending press
        do_reset();
        evt_ready = 1'b0;
        key       = 4'b0111;
        tick();
        key = 4'b0000;
        for (int c = 0; c < 6; c++) tick();
        key = 4'b0001;
        tick();
        key = 4'b0000;
        tick();
        check("ovf.pre", ovf, 0);
        key = 4'b0001;
        tick();
        check("ovf.set", ovf, 1);
        tick();
        check("ovf.sticky", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf.clear", ovf, 0);
        key     = 4'b0000;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf.set_over_clr", ovf, 1);

        // reset with three events queued, key 0 held through reset
        do_reset();
        evt_ready = 1'b0;
        key       = 4'b0111;
        for (int c = 0; c < 4; c++) tick();
        check("mid.count", fifo_count, 3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid.valid_rst", evt_valid, 0);
        check("mid.count_rst", fifo_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("mid.valid_e1", evt_valid, 0);
        tick();
        check("mid.valid_e2", evt_valid, 1);
        check("mid.key_e2", evt_key, 0);
        check("mid.type_e2", evt_type, 0);

        // randomized traffic against the model
        do_reset();
        key       = '0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if ($urandom_range(0, 11) == 0) key[i] = ~key[i];
            end
            evt_ready = ($urandom_range(0, 9) < 5);
            clr_ovf   = ($urandom_range(0, 31) == 0);
            if (c == 1500) do_reset();
            tick();
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of debounced key inputs (2..8).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, hold duration in clk cycles for a long-press event (0.5 s at 100 MHz; minimum 2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, event queue depth (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port key, input, N_KEYS, debounced key levels, synchronous to clk, 1 = pressed.
REQ-007 SHALL have port evt_valid, output, 1, high when the queue head holds an event.
REQ-008 SHALL have port evt_ready, input, 1, consumer accepts the head event when evt_valid is also high.
REQ-009 SHALL have port evt_key, output, clog2(N_KEYS), key index of the head event.
REQ-010 SHALL have port evt_type, output, 2, head event type: 00 press, 01 long, 10 release; 11 is never emitted.
REQ-011 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1, number of queued events.
REQ-012 SHALL have port ovf, output, 1, sticky flag for a lost event.
REQ-013 SHALL have port clr_ovf, input, 1, synchronous clear for ovf.

Function
REQ-014 SHALL register key into key_q every cycle; press[i] = key[i] & ~key_q[i]; release[i] = ~key[i] & key_q[i].
REQ-015 SHALL keep a per-key hold counter: cleared on press; incremented each cycle while key_q[i] = 1; saturating at LONG_CYCLES-1; cleared while key_q[i] = 0.
REQ-016 SHALL raise long[i] for exactly one cycle, on the cycle the hold counter increments to LONG_CYCLES-1; a key released earlier SHALL never raise long.
REQ-017 SHALL keep three pending flags per key (P, L, R), set at the clock edge following the corresponding press, long or release strobe.
REQ-018 SHALL set ovf when a strobe occurs while its own pending flag is already set and not being granted in that cycle; the flag stays set, so the duplicate event is lost.
REQ-019 SHALL grant at most one pending flag per cycle, and only when fifo_count < FIFO_DEPTH at the start of that cycle; no grant is allowed in the same cycle as a pop at full.
REQ-020 SHALL pick among keys in round-robin order, starting at (last_granted_key + 1) mod N_KEYS; last_granted_key resets to N_KEYS-1, so key 0 has first priority.
REQ-021 SHALL, within one key, grant in the fixed priority P > L > R, which preserves chronological order.
REQ-022 SHALL, on a grant, clear that pending flag, write {key index, type} to the FIFO tail and update last_granted_key, all at the same edge.
REQ-023 SHALL give pending-flag set priority over grant-clear when both hit the same flag in the same cycle; the flag stays set and ovf is unchanged.
REQ-024 SHALL drive evt_valid = (fifo_count != 0), with evt_key and evt_type driven directly from the head entry and held stable while evt_valid & ~evt_ready.
REQ-025 SHALL pop on evt_valid & evt_ready; a push and a pop in the same cycle leave fifo_count unchanged.
REQ-026 SHALL give latency of 2 edges: with the FIFO empty and nothing else pending, evt_valid goes high 2 clk edges after the edge at which key[i] is first sampled high.
REQ-027 SHALL give set priority over clr_ovf when both occur in the same cycle.
REQ-028 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear key_q, all hold counters, all pending flags, the FIFO pointers, fifo_count and ovf, and set last_granted_key to N_KEYS-1.
REQ-030 SHALL hold, during reset, evt_valid = 0, evt_key = 0, evt_type = 00, fifo_count = 0 and ovf = 0.
REQ-031 SHALL discard any queued events if reset is asserted mid-operation.
REQ-032 SHALL report a press event after reset release for any key already high at that time, because key_q is 0.

Verification
REQ-033 SHALL cover single press: key[2] 0->1, evt_ready=1 -> evt_valid high 2 edges later with evt_key=2, evt_type=00, for 1 cycle; fifo_count returns to 0.
REQ-034 SHALL cover long press: LONG_CYCLES=10, key[1] held 20 cycles then released -> events (1,00), (1,01), (1,10) in order, with exactly one long event.
REQ-035 SHALL cover simultaneous press: key[3:0] 0000->1111 at one edge, evt_ready=1 -> evt_key order 0,1,2,3 on consecutive cycles, all type 00.
REQ-036 SHALL cover backpressure: evt_ready=0, 6 distinct press/release events -> fifo_count saturates at 4 with the remaining events held pending and ovf=0; after evt_ready=1 all 6 are delivered in order.
REQ-037 SHALL cover overflow: evt_ready=0, FIFO full, key[0] toggled 0->1->0->1 -> ovf=1; clr_ovf pulse with no new strobe -> ovf=0.
REQ-038 SHALL cover reset mid-queue: fifo_count=3, rst_n pulsed low -> evt_valid=0 and fifo_count=0 immediately; with key[0] held high, evt (0,00) appears 2 edges after reset release.
